// File: rtl/ars_cbc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : ars_cbc_ctrl_if
// Desc    : Host stream, core handshake and status bundle for ars_cbc_ctrl.
// Rev     : 1.0
// ============================================================================
interface ars_cbc_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic             mode;
   logic [127:0]     key;
   logic [127:0]     iv;
   logic             in_valid;
   logic             in_ready;
   logic [127:0]     in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [127:0]     out_data;
   logic             out_last;
   logic             core_load;
   logic             core_enc;
   logic [127:0]     core_din;
   logic [127:0]     core_key;
   logic             core_ready;
   logic [127:0]     core_dout;
   logic             busy;
   logic             done;
   logic             error;
   logic [CNT_W-1:0] blk_cnt;

   modport slave (
      input  start, mode, key, iv, in_valid, in_data, in_last, out_ready,
             core_ready, core_dout,
      output in_ready, out_valid, out_data, out_last, core_load, core_enc,
             core_din, core_key, busy, done, error, blk_cnt
   );

   modport master (
      output start, mode, key, iv, in_valid, in_data, in_last, out_ready,
             core_ready, core_dout,
      input  in_ready, out_valid, out_data, out_last, core_load, core_enc,
             core_din, core_key, busy, done, error, blk_cnt
   );
endinterface
`default_nettype wire

// File: rtl/ars_cbc_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ars_cbc_ctrl
// Desc    : CBC encrypt/decrypt sequencer for one block-cipher core (load/ready).
//           Optional core-ready watchdog: define ARS_CBC_TIMEOUT_EN.
// Rev     : 1.0
// ============================================================================
module ars_cbc_ctrl #(
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  wire logic     clk,
   input  wire logic     reset,
   ars_cbc_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WAIT_IN = 3'd1,
      S_LOAD    = 3'd2,
      S_BUSY    = 3'd3,
      S_OUT     = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [127:0]     r_chain;
   logic [127:0]     r_blk;
   logic [127:0]     r_key;
   logic [127:0]     r_din;
   logic [127:0]     r_out_data;
   logic             r_last;
   logic             r_mode;
   logic             r_out_last;
   logic             r_busy;
   logic             r_done;
   logic             r_error;
   logic [CNT_W-1:0] r_cnt;
   logic             w_timeout;

`ifdef ARS_CBC_TIMEOUT_EN
   localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [c_TO_W-1:0] r_to_cnt;

   always_ff @(posedge clk) begin
      if (reset || r_state == S_LOAD) begin
         r_to_cnt <= '0;
      end else if (r_state == S_BUSY) begin
         r_to_cnt <= r_to_cnt + c_TO_W'(1);
      end
   end

   // Fires on the last permitted BUSY cycle; a same-cycle core_ready wins.
   assign w_timeout = (r_state == S_BUSY) && !bus.core_ready &&
                      (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));
`else
   wire [31:0] w_unused_timeout = TIMEOUT_CYCLES;
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_nxt = S_WAIT_IN;
            end
         end
         S_WAIT_IN: begin
            if (bus.in_valid) begin
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            w_state_nxt = S_BUSY;
         end
         S_BUSY: begin
            if (bus.core_ready) begin
               w_state_nxt = S_OUT;
            end else if (w_timeout) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_OUT: begin
            if (bus.out_ready) begin
               w_state_nxt = r_last ? S_IDLE : S_WAIT_IN;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_chain    <= '0;
         r_blk      <= '0;
         r_key      <= '0;
         r_din      <= '0;
         r_out_data <= '0;
         r_last     <= 1'b0;
         r_mode     <= 1'b0;
         r_out_last <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_chain <= bus.iv;
                  r_key   <= bus.key;
                  r_mode  <= bus.mode;
                  r_cnt   <= '0;
                  r_error <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            S_WAIT_IN: begin
               if (bus.in_valid) begin
                  r_blk  <= bus.in_data;
                  r_last <= bus.in_last;
                  r_din  <= r_mode ? (bus.in_data ^ r_chain) : bus.in_data;
               end
            end
            S_BUSY: begin
               // Chaining advances only here, so output stalls cannot disturb it.
               if (bus.core_ready) begin
                  r_out_data <= r_mode ? bus.core_dout : (bus.core_dout ^ r_chain);
                  r_chain    <= r_mode ? bus.core_dout : r_blk;
                  r_out_last <= r_last;
                  r_cnt      <= r_cnt + CNT_W'(1);
               end else if (w_timeout) begin
                  r_error <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            S_OUT: begin
               if (bus.out_ready && r_last) begin
                  r_done <= 1'b1;
                  r_busy <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.in_ready  = (r_state == S_WAIT_IN);
   assign bus.out_valid = (r_state == S_OUT);
   assign bus.core_load = (r_state == S_LOAD);
   assign bus.out_data  = r_out_data;
   assign bus.out_last  = r_out_last;
   assign bus.core_enc  = r_mode;
   assign bus.core_din  = r_din;
   assign bus.core_key  = r_key;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.error     = r_error;
   assign bus.blk_cnt   = r_cnt;

endmodule
`default_nettype wire
